// File: rtl/nv_blkbox_src_gen.sv
// Blackbox source generator: drives a bounded burst of deterministic beats on a valid/ready port.
// Optional macro NV_BLKBOX_SRC_BUBBLE_EN inserts a one-cycle valid bubble after every non-final beat.
module nv_blkbox_src_gen #(
  parameter int          DW        = 32,
  parameter int          BURST_W   = 16,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic [1:0]         cfg_mode,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               src_pvld,
  input  logic               src_prdy,
  output logic [DW-1:0]      src_pd
);

  // Handshake: a beat transfers on any rising edge where src_pvld && src_prdy; while
  // src_pvld is high and src_prdy low, src_pd is held and src_pvld stays asserted.

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

`ifdef NV_BLKBOX_SRC_BUBBLE_EN
  localparam logic BUBBLE = 1'b1;
`else
  localparam logic BUBBLE = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [BURST_W-1:0] len_q;
  logic [BURST_W-1:0] beat_q;
  logic [DW-1:0]      count_q;
  logic [DW-1:0]      count_nx;
  logic [31:0]        lfsr_q;
  logic [31:0]        lfsr_nx;
  logic               pvld_q;
  logic [DW-1:0]      pd_q;
  logic               accept;
  logic               xfer;
  logic               last_beat;

  // Feedback bit rotates into bit 31 and toggles the remaining tap positions.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = (v >> 1) ^ ({32{v[0]}} & {LFSR_TAPS[31:1], 1'b0});
  endfunction

  function automatic logic [DW-1:0] pattern(input logic [1:0]    m,
                                            input logic [DW-1:0] c,
                                            input logic [31:0]   l);
    case (m)
      2'd0:    pattern = '0;
      2'd1:    pattern = '1;
      2'd2:    pattern = c;
      default: pattern = l[DW-1:0];
    endcase
  endfunction

  assign accept    = (state_q == ST_IDLE) && start;
  assign xfer      = (state_q == ST_RUN) && pvld_q && src_prdy;
  assign last_beat = (beat_q == (len_q - BURST_W'(1)));
  assign count_nx  = count_q + DW'(1);
  assign lfsr_nx   = lfsr_step(lfsr_q);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (cfg_burst_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (xfer && last_beat) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      mode_q  <= 2'd0;
      len_q   <= '0;
      beat_q  <= '0;
      count_q <= '0;
      lfsr_q  <= LFSR_SEED;
      pvld_q  <= 1'b0;
      pd_q    <= '0;
    end else if (accept) begin
      mode_q  <= cfg_mode;
      len_q   <= cfg_burst_len;
      beat_q  <= '0;
      count_q <= '0;
      lfsr_q  <= LFSR_SEED;
      if (cfg_burst_len != '0) begin
        pvld_q <= 1'b1;
        pd_q   <= pattern(cfg_mode, '0, LFSR_SEED);
      end
    end else if (state_q == ST_RUN) begin
      if (xfer) begin
        if (last_beat) begin
          pvld_q <= 1'b0;
        end else begin
          beat_q  <= beat_q + BURST_W'(1);
          count_q <= count_nx;
          lfsr_q  <= lfsr_nx;
          pd_q    <= pattern(mode_q, count_nx, lfsr_nx);
          pvld_q  <= !BUBBLE;
        end
      end else if (!pvld_q) begin
        // End of a bubble: next payload was already loaded at the transfer.
        pvld_q <= 1'b1;
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign src_pvld = pvld_q;
  assign src_pd   = pd_q;

endmodule

// File: tb/tb_nv_blkbox_src_gen.sv
// Directed bench for nv_blkbox_src_gen: a 32-bit instance and a 4-bit instance share stimulus.
module tb_nv_blkbox_src_gen;

  logic        clk;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_burst_len;
  logic        start;
  logic        prdy;
  logic        sel;

  logic        start_a, start_b;
  logic        busy_a, done_a, pvld_a;
  logic [31:0] pd_a;
  logic        busy_b, done_b, pvld_b;
  logic [3:0]  pd_b;

  logic        mon_pvld, mon_busy, mon_done;
  logic [31:0] mon_pd;

  logic [31:0] exp_q[$];
  int          n_pass;
  int          n_total;

  assign start_a  = start && !sel;
  assign start_b  = start && sel;
  assign mon_pvld = sel ? pvld_b : pvld_a;
  assign mon_busy = sel ? busy_b : busy_a;
  assign mon_done = sel ? done_b : done_a;
  assign mon_pd   = sel ? {28'd0, pd_b} : pd_a;

  nv_blkbox_src_gen #(.DW(32), .BURST_W(16), .LFSR_SEED(32'h0000_0001)) u_dut_a (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_mode       (cfg_mode),
    .cfg_burst_len  (cfg_burst_len),
    .start          (start_a),
    .busy           (busy_a),
    .done           (done_a),
    .src_pvld       (pvld_a),
    .src_prdy       (prdy),
    .src_pd         (pd_a)
  );

  nv_blkbox_src_gen #(.DW(4), .BURST_W(16), .LFSR_SEED(32'h0000_0001)) u_dut_b (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_mode       (cfg_mode),
    .cfg_burst_len  (cfg_burst_len),
    .start          (start_b),
    .busy           (busy_b),
    .done           (done_b),
    .src_pvld       (pvld_b),
    .src_prdy       (prdy),
    .src_pd         (pd_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Pulses start, then watches the selected DUT each cycle until done, scoring beats
  // against exp_q and checking that stalled payloads hold.
  task automatic run_burst(input logic s, input logic [1:0] mode, input logic [15:0] len,
                           input logic [7:0] prdy_pat, input int extra_cyc, input string tag,
                           output int beats, output int done_cyc, output logic [7:0] vld_hist);
    logic        stall;
    logic [31:0] held;
    logic        finished;
    beats = 0; done_cyc = 0; vld_hist = '0; stall = 1'b0; held = '0; finished = 1'b0;
    sel = s; cfg_mode = mode; cfg_burst_len = len; prdy = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
      prdy = prdy_pat[(cyc - 1) % 8];
      if (cyc == extra_cyc) begin
        start = 1'b1; cfg_burst_len = 16'd2; cfg_mode = 2'd0;
      end else begin
        start = 1'b0;
      end
      if (cyc <= 8) vld_hist[cyc - 1] = mon_pvld;
      if (stall) begin
        check({tag, " stall_pvld"}, {31'd0, mon_pvld}, 32'd1);
        check({tag, " stall_pd"}, mon_pd, held);
      end
      stall = mon_pvld && !prdy;
      held  = mon_pd;
      if (mon_pvld && prdy) begin
        if (exp_q.size() > 0) check({tag, " beat"}, mon_pd, exp_q.pop_front());
        beats++;
      end
      if (mon_done) begin
        done_cyc = cyc;
        finished = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    prdy  = 1'b1;
    check({tag, " done_seen"}, {31'd0, finished}, 32'd1);
    check({tag, " busy_after"}, {31'd0, mon_busy}, 32'd0);
    check({tag, " done_one_cycle"}, {31'd0, mon_done}, 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic            sel;
    logic [1:0]      mode;
    logic [15:0]     len;
    logic [7:0]      prdy;
    logic [5:0][31:0] exp;
    int              done_nb;
    int              done_bb;
    logic [4:0]      hist_nb;
    logic [4:0]      hist_bb;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          beats, done_cyc;
    logic [7:0]  hist;
    int          exp_done;
    logic [4:0]  exp_hist;

    n_pass = 0; n_total = 0;
    rst = 1'b1; start = 1'b0; sel = 1'b0; cfg_mode = 2'd0; cfg_burst_len = 16'd0; prdy = 1'b1;

    vecs[0] = '{1'b0, 2'd2, 16'd4, 8'hFF, {32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0}, 5, 8, 5'b01111, 5'b10101};
    vecs[1] = '{1'b0, 2'd3, 16'd3, 8'b1111_1001,
                {32'd0, 32'd0, 32'd0, 32'h4010_0001, 32'h8020_0002, 32'h0000_0001}, 6, 7, 5'b11111, 5'b01101};
    vecs[2] = '{1'b0, 2'd1, 16'd2, 8'hFF, {32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 3, 4, 5'b00011, 5'b00101};
    vecs[3] = '{1'b0, 2'd0, 16'd3, 8'hFF, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 4, 6, 5'b00111, 5'b10101};
    vecs[4] = '{1'b1, 2'd1, 16'd2, 8'hFF, {32'd0, 32'd0, 32'd0, 32'd0, 32'hF, 32'hF}, 3, 4, 5'b00011, 5'b00101};
    vecs[5] = '{1'b1, 2'd0, 16'd2, 8'hFF, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 3, 4, 5'b00011, 5'b00101};
    vecs[6] = '{1'b0, 2'd3, 16'd5, 8'hFF,
                {32'd0, 32'h5014_0001, 32'hA028_0002, 32'h4010_0001, 32'h8020_0002, 32'h0000_0001}, 6, 10, 5'b11111, 5'b10101};
    vecs[7] = '{1'b1, 2'd3, 16'd3, 8'hFF, {32'd0, 32'd0, 32'd0, 32'h1, 32'h2, 32'h1}, 4, 6, 5'b00111, 5'b10101};
    vecs[8] = '{1'b0, 2'd2, 16'd3, 8'hFF, {32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0}, 4, 6, 5'b00111, 5'b10101};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset pvld_a", {31'd0, pvld_a}, 32'd0);
    check("reset busy_a", {31'd0, busy_a}, 32'd0);
    check("reset done_a", {31'd0, done_a}, 32'd0);
    check("reset pd_a", pd_a, 32'd0);
    check("reset pvld_b", {31'd0, pvld_b}, 32'd0);
    check("reset pd_b", {28'd0, pd_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven bursts
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < int'(vecs[i].len); k++) exp_q.push_back(vecs[i].exp[k]);
`ifdef NV_BLKBOX_SRC_BUBBLE_EN
      exp_done = vecs[i].done_bb;
      exp_hist = vecs[i].hist_bb;
`else
      exp_done = vecs[i].done_nb;
      exp_hist = vecs[i].hist_nb;
`endif
      run_burst(vecs[i].sel, vecs[i].mode, vecs[i].len, vecs[i].prdy, 0,
                $sformatf("vec%0d", i), beats, done_cyc, hist);
      check($sformatf("vec%0d beats", i), 32'(beats), 32'(vecs[i].len));
      check($sformatf("vec%0d done_cycle", i), 32'(done_cyc), 32'(exp_done));
      check($sformatf("vec%0d pvld_pattern", i), {27'd0, hist[4:0]}, {27'd0, exp_hist});
      check($sformatf("vec%0d pd_retained", i), mon_pd, vecs[i].exp[vecs[i].len - 16'd1]);
    end

    // zero length: done the cycle after start, no valid
    sel = 1'b0; cfg_mode = 2'd2; cfg_burst_len = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_len done", {31'd0, done_a}, 32'd1);
    check("zero_len pvld", {31'd0, pvld_a}, 32'd0);
    check("zero_len busy", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    check("zero_len done_clear", {31'd0, done_a}, 32'd0);
    check("zero_len busy_clear", {31'd0, busy_a}, 32'd0);
    check("zero_len pvld_after", {31'd0, pvld_a}, 32'd0);

    // start while busy (with changed cfg) must not disturb the running burst
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
    run_burst(1'b0, 2'd2, 16'd4, 8'hFF, 2, "busy_start", beats, done_cyc, hist);
    check("busy_start beats", 32'(beats), 32'd4);
    repeat (2) @(negedge clk);
    check("busy_start no_new_burst", {30'd0, pvld_a, busy_a}, 32'd0);

    // 4-bit count wraps modulo 16
    for (int k = 0; k < 18; k++) exp_q.push_back(32'(k % 16));
    run_burst(1'b1, 2'd2, 16'd18, 8'hFF, 0, "wrap4", beats, done_cyc, hist);
    check("wrap4 beats", 32'(beats), 32'd18);
    check("wrap4 pd_retained", {28'd0, pd_b}, 32'd1);

    // reset mid-burst, then a fresh burst restarts the count
    sel = 1'b0; cfg_mode = 2'd2; cfg_burst_len = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst pvld_before", {31'd0, pvld_a}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst pvld", {31'd0, pvld_a}, 32'd0);
    check("midrst busy", {31'd0, busy_a}, 32'd0);
    check("midrst done", {31'd0, done_a}, 32'd0);
    check("midrst pd", pd_a, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    run_burst(1'b0, 2'd2, 16'd2, 8'hFF, 0, "after_rst", beats, done_cyc, hist);
    check("after_rst beats", 32'(beats), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nv_blkbox_src_gen.md
Name: nv_blkbox_src_gen

Overview:
- Active counterpart of the blackbox sink, used wherever a black-boxed or stubbed partition must feed a live datapath.
- A sink only terminates a net. This block drives one: it generates a bounded burst of deterministic data beats on a valid/ready interface.
- Data patterns are constant-0, constant-1, an incrementing count, or a 32-bit LFSR.
- Placed at partition boundaries for tie-off replacement, bring-up traffic and sink-side loopback checks.

Parameters:
- DW, 32, payload width; legal range 1..32.
- BURST_W, 16, width of the burst-length config and the beat counter.
- LFSR_SEED, 32'h0000_0001, LFSR value loaded at each start; must be nonzero.

Ports:
- nvdla_core_clk  input  1  core clock; all logic on rising edge.
- nvdla_core_rst  input  1  reset; synchronous, active-high.
- cfg_mode  input  2  pattern select: 0=zeros, 1=ones, 2=count, 3=LFSR.
- cfg_burst_len  input  BURST_W  number of beats per burst.
- start  input  1  one-cycle request to begin a burst.
- busy  output  1  high from the cycle after an accepted start until the cycle before idle.
- done  output  1  one-cycle pulse when a burst completes.
- src_pvld  output  1  payload valid.
- src_prdy  input  1  payload ready from downstream.
- src_pd  output  DW  payload.

Behaviour:
- Reset (sync, high, sampled at clock edge): state=IDLE, busy=0, done=0, src_pvld=0, src_pd=0, beat counter=0, count register=0, LFSR=LFSR_SEED. Reset wins over every other event, including mid-burst; src_pvld is 0 in the cycle after reset is sampled.
- FSM states:
  - IDLE: start=1 latches cfg_mode and cfg_burst_len. If the latched len==0, go to DONE. Otherwise go to RUN with beat counter=0, count=0, LFSR=LFSR_SEED.
  - RUN: src_pvld=1. A beat transfers when src_pvld && src_prdy. When the transfer is beat index len-1, go to DONE.
  - DONE: done=1 for exactly one cycle, src_pvld=0, then IDLE.
- Latency: start sampled in cycle N → src_pvld=1 in cycle N+1. With src_prdy held high, one beat per cycle.
- start while busy or in DONE is ignored. cfg_* changes after start have no effect on the running burst.
- busy=1 in RUN and DONE.
- Handshake: src_pd and src_pvld are registered. While src_pvld && !src_prdy, src_pd holds stable. src_pvld never drops in RUN without a transfer.
- Payload per mode:
  - 0: all zeros.
  - 1: all ones.
  - 2: count[DW-1:0]. count starts at 0 and increments by 1 per transfer, wrapping modulo 2^DW.
  - 3: LFSR[DW-1:0]. 32-bit Galois, right-shift, taps 0x80200003. Advances one step per transfer. The first beat is LFSR_SEED.
- Beat counter is BURST_W bits; cfg_burst_len = 2^BURST_W-1 is the maximum burst.
- src_pd after a burst retains the last value driven; only reset clears it.

Optional Feature:
- Macro NV_BLKBOX_SRC_BUBBLE_EN.
- Defined: after every transferred beat that is not the last beat, src_pvld drops for exactly one cycle, then reasserts with the next payload. Maximum throughput is one beat per two cycles; pattern sequence is unchanged.
- Undefined: no bubbles; back-to-back beats when src_prdy=1.

Test Plan:
- Reset mid-burst: mode=2, len=10, reset asserted after beat 3 → src_pvld=0, busy=0 next cycle; a new start with len=2 yields payloads 0,1.
- Count burst: mode=2, len=4, prdy=1 → beats 0,1,2,3 in four consecutive cycles starting cycle N+1; done pulses once in cycle N+5; busy falls after.
- Backpressure: mode=3, len=3, prdy toggled 1,0,0,1,1 → src_pd held stable during stalls. Payloads: 0x00000001, 0x80200002, 0x40100001.
- Zero length: len=0, start → no src_pvld; done pulses the cycle after start. Start during busy → ignored, burst count unchanged.
- Wrap and constants: DW=4, mode=2, len=18 → beats 0..15, 0, 1. Mode 1, len=2 → 4'hF twice. Mode 0 → 0.
- With NV_BLKBOX_SRC_BUBBLE_EN: mode=2, len=3, prdy=1 → src_pvld pattern 1,0,1,0,1 with payloads 0,1,2; done follows the third beat.
